// File: rtl/m_dm.sv
// Memory-stage data memory: byte-enabled stores, zero-latency word reads,
// self-timed clear after reset, and a registered trace of committed stores.
module m_dm #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        we,
    input  logic [1:0]  st_c,
    input  logic        ld_word,
    input  logic        ld_half,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic        err,
    output logic        ready,
    output logic        trace_valid,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] init_idx_q, init_idx_d;
    logic                  trace_valid_q, trace_valid_d;
    logic [31:0]           trace_addr_q, trace_addr_d;
    logic [31:0]           trace_data_q, trace_data_d;

    logic [31:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  oor;
    logic                  misaligned;
    logic                  commit;
    logic [31:0]           old_word;
    logic [31:0]           lane_data;
    logic [31:0]           merged_word;

    assign ready    = (state_q == RUN);
    assign word_idx = addr[DEPTH_LOG2+1:2];
    assign oor      = |addr[31:DEPTH_LOG2+2];
    assign old_word = mem[word_idx];

    // Reserved store code counts as misaligned so it is rejected like any bad access.
    always_comb begin
        misaligned = 1'b0;
        if (we) begin
            case (st_c)
                2'b00:   misaligned = |addr[1:0];
                2'b01:   misaligned = addr[0];
                2'b10:   misaligned = 1'b0;
                default: misaligned = 1'b1;
            endcase
        end else if (ld_word) begin
            misaligned = |addr[1:0];
        end else if (ld_half) begin
            misaligned = addr[0];
        end
    end

    assign err    = req_valid & ready & (oor | misaligned);
    assign commit = req_valid & we & ready & ~oor & ~misaligned;

    always_comb begin
        byte_en   = 4'b0000;
        lane_data = {4{wdata[7:0]}};
        case (st_c)
            2'b00: begin
                lane_data = wdata;
                if (commit) byte_en = 4'b1111;
            end
            2'b01: begin
                lane_data = {2{wdata[15:0]}};
                if (commit) byte_en = addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                if (commit) byte_en = 4'b0001 << addr[1:0];
            end
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged_word[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

    assign rdata = (ready && !oor) ? old_word : 32'h0;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (&init_idx_q) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        trace_valid_d = commit;
        trace_addr_d  = commit ? {addr[31:2], 2'b00} : trace_addr_q;
        trace_data_d  = commit ? merged_word : trace_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= INIT;
            init_idx_q    <= '0;
            trace_valid_q <= 1'b0;
            trace_addr_q  <= 32'h0;
            trace_data_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            trace_valid_q <= trace_valid_d;
            trace_addr_q  <= trace_addr_d;
            trace_data_q  <= trace_data_d;
        end
    end

    // The array has no reset; it is wiped one word per edge while in INIT.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[init_idx_q] <= 32'h0;
        end else if (commit) begin
            mem[word_idx] <= merged_word;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_m_dm.sv
// Self-checking bench for m_dm: byte-level reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_m_dm;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  st_c = 2'b00;
    logic        ld_word = 1'b0;
    logic        ld_half = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [3:0]  byte_en;
    logic        err;
    logic        ready;
    logic        trace_valid;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    int n_compared = 0;
    int n_mismatched = 0;

    m_dm #(.DEPTH_LOG2(10)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .we(we),
        .st_c(st_c), .ld_word(ld_word), .ld_half(ld_half), .addr(addr),
        .wdata(wdata), .rdata(rdata), .byte_en(byte_en), .err(err),
        .ready(ready), .trace_valid(trace_valid), .trace_addr(trace_addr),
        .trace_data(trace_data)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain byte view of memory and an edge counter since reset.
    logic [31:0] mm [DEPTH];
    int          init_edges = 0;
    logic        m_tv = 1'b0;
    logic [31:0] m_ta = 32'h0;
    logic [31:0] m_td = 32'h0;
    logic [3:0]  m_ln;

    function automatic int acc_size();
        if (we) begin
            case (st_c)
                2'b00:   return 4;
                2'b01:   return 2;
                2'b10:   return 1;
                default: return 0;
            endcase
        end
        if (ld_word) return 4;
        if (ld_half) return 2;
        return 1;
    endfunction

    function automatic logic m_ready();
        return init_edges >= DEPTH;
    endfunction

    function automatic logic m_in_range();
        return addr < 32'(4 * DEPTH);
    endfunction

    function automatic logic m_err();
        int sz;
        int off;
        logic bad;
        sz  = acc_size();
        off = int'(addr[1:0]);
        bad = (sz == 0) || ((off % sz) != 0);
        return req_valid && m_ready() && (!m_in_range() || bad);
    endfunction

    function automatic logic [3:0] m_lanes();
        logic [3:0] l;
        int sz;
        int off;
        l   = 4'b0000;
        sz  = acc_size();
        off = int'(addr[1:0]);
        if (req_valid && we && m_ready() && !m_err()) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + sz) l[b] = 1'b1;
            end
        end
        return l;
    endfunction

    function automatic logic [31:0] m_rdata();
        if (m_ready() && m_in_range()) return mm[addr[11:2]];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_merged(input logic [3:0] l);
        logic [31:0] w;
        int off;
        w   = mm[addr[11:2]];
        off = int'(addr[1:0]);
        for (int b = 0; b < 4; b++) begin
            if (l[b]) w[8*b +: 8] = wdata[8*(b-off) +: 8];
        end
        return w;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
            init_edges = 0;
            m_tv = 1'b0;
            m_ta = 32'h0;
            m_td = 32'h0;
        end else begin
            m_ln = m_lanes();
            if (m_ln != 4'b0000) begin
                m_td = m_merged(m_ln);
                m_ta = {addr[31:2], 2'b00};
                mm[addr[11:2]] = m_td;
                m_tv = 1'b1;
            end else begin
                m_tv = 1'b0;
            end
            if (init_edges < DEPTH) init_edges++;
        end
    end

    always @(negedge clk) begin
        check_output("cmp_rdata", rdata, m_rdata());
        check_output("cmp_byte_en", 32'(byte_en), 32'(m_lanes()));
        check_output("cmp_err", 32'(err), 32'(m_err()));
        check_output("cmp_ready", 32'(ready), 32'(m_ready()));
        check_output("cmp_trace_valid", 32'(trace_valid), 32'(m_tv));
        check_output("cmp_trace_addr", trace_addr, m_ta);
        check_output("cmp_trace_data", trace_data, m_td);
    end

    task automatic apply_stimulus(input logic rv, input logic w, input logic [1:0] sc,
                                  input logic lw, input logic lh,
                                  input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req_valid = rv;
        we        = w;
        st_c      = sc;
        ld_word   = lw;
        ld_half   = lh;
        addr      = a;
        wdata     = d;
        #1;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sc;
        logic        lw;
        logic        lh;
        logic [31:0] a;
    } bad_vec_t;

    bad_vec_t bad_vecs [5];

    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
        bad_vecs[0] = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0022};
        bad_vecs[1] = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0013};
        bad_vecs[2] = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0001};
        bad_vecs[3] = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_1000};
        bad_vecs[4] = '{1'b1, 2'b11, 1'b0, 1'b0, 32'h0000_0010};

        repeat (3) @(posedge clk);
        #2;
        check_output("rst_ready", 32'(ready), 32'h0);
        check_output("rst_trace_valid", 32'(trace_valid), 32'h0);
        check_output("rst_trace_addr", trace_addr, 32'h0);
        check_output("rst_trace_data", trace_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int e = 1; e <= DEPTH; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) begin
                req_valid = 1'b1; we = 1'b1; st_c = 2'b00; addr = 32'h0; wdata = 32'hFFFF_FFFF;
            end
            if (e == 4) begin
                req_valid = 1'b0; we = 1'b0;
            end
            #1;
            if (e == 3) begin
                check_output("init_store_err", 32'(err), 32'h0);
                check_output("init_store_be", 32'(byte_en), 32'h0);
                check_output("init_rdata", rdata, 32'h0);
            end
            if (e == DEPTH - 1) check_output("ready_before_last", 32'(ready), 32'h0);
            if (e == DEPTH) check_output("ready_after_last", 32'(ready), 32'h1);
        end

        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0);
        check_output("lw_0ffc", rdata, 32'h0000_0000);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        check_output("lw_0_after_init_store", rdata, 32'h0000_0000);

        apply_stimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0010, 32'h1234_5678);
        check_output("sw_be", 32'(byte_en), 32'hF);
        check_output("sw_err", 32'(err), 32'h0);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0013, 32'h0);
        check_output("lb_rdata", rdata, 32'h1234_5678);
        check_output("lb_be", 32'(byte_en), 32'h0);
        check_output("lb_lane3", {24'h0, rdata[31:24]}, 32'h12);
        check_output("sw_trace_valid", 32'(trace_valid), 32'h1);
        check_output("sw_trace_addr", trace_addr, 32'h0000_0010);
        check_output("sw_trace_data", trace_data, 32'h1234_5678);

        apply_stimulus(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0011, 32'h0000_00AB);
        check_output("sb_be", 32'(byte_en), 32'h2);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check_output("sb_rdata", rdata, 32'h1234_AB78);
        check_output("sb_trace_data", trace_data, 32'h1234_AB78);
        apply_stimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0012, 32'h0000_BEEF);
        check_output("sh_be", 32'(byte_en), 32'hC);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check_output("sh_rdata", rdata, 32'hBEEF_AB78);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, bad_vecs[i].w, bad_vecs[i].sc, bad_vecs[i].lw,
                           bad_vecs[i].lh, bad_vecs[i].a, 32'hDEAD_BEEF);
            check_output($sformatf("bad%0d_err", i), 32'(err), 32'h1);
            check_output($sformatf("bad%0d_be", i), 32'(byte_en), 32'h0);
            check_output($sformatf("bad%0d_trace_valid", i), 32'(trace_valid), 32'h0);
            if (i == 3) check_output("oor_rdata", rdata, 32'h0);
        end
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check_output("bad_word_unchanged", rdata, 32'hBEEF_AB78);
        check_output("bad_no_trace", 32'(trace_valid), 32'h0);

        apply_stimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0010, 32'hCAFE_F00D);
        check_output("same_cycle_old", rdata, 32'hBEEF_AB78);
        apply_stimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0014, 32'h0000_0055);
        check_output("b2b_trace_data0", trace_data, 32'hCAFE_F00D);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0014, 32'h0);
        check_output("b2b_trace_valid", 32'(trace_valid), 32'h1);
        check_output("b2b_trace_addr", trace_addr, 32'h0000_0014);
        check_output("word5_rdata", rdata, 32'h0000_0055);

        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("midrun_ready", 32'(ready), 32'h0);
        check_output("midrun_trace_valid", 32'(trace_valid), 32'h0);
        check_output("midrun_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (DEPTH) @(posedge clk);
        #2;
        check_output("reinit_ready", 32'(ready), 32'h1);
        check_output("reinit_word5", rdata, 32'h0);

        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/m_dm.md
# m_dm

Memory-stage data memory for the pipelined MIPS core. It sits directly upstream of the M-stage load extender and supplies the raw aligned 32-bit word that the extender slices and sign/zero-extends for lw/lh/lhu/lb/lbu. It performs byte-enabled stores for sw/sh/sb and flags misaligned or out-of-range accesses. After every reset it clears its array with a self-timed sequence and holds `ready` low until that finishes. A registered write trace is exported for the testbench log.

## Interface
Parameters:
- `DEPTH_LOG2`, 10, log2 of word count; DEPTH = 2^DEPTH_LOG2 words, byte range 0 .. 4*DEPTH-1.

Ports:
- `clk` in 1, single clock; all state changes on the rising edge.
- `reset_n` in 1, asynchronous active-low reset.
- `req_valid` in 1, M stage presents an access this cycle.
- `we` in 1, 1 = store, 0 = load.
- `st_c` in 2, store width: 2'b00 sw, 2'b01 sh, 2'b10 sb, 2'b11 reserved.
- `ld_word` in 1, load is word-sized (lw); used only for the alignment check.
- `ld_half` in 1, load is half-sized (lh/lhu); used only for the alignment check.
- `addr` in 32, byte address.
- `wdata` in 32, store data, right-justified.
- `rdata` out 32, raw word at `addr[DEPTH_LOG2+1:2]`; combinational and consumed in the same cycle by the extender.
- `byte_en` out 4, lane enables of the current store; combinational.
- `err` out 1, misaligned, out-of-range, or reserved-code access; combinational.
- `ready` out 1, clear sequence complete; accesses are honoured only while high.
- `trace_valid` out 1, registered pulse marking one committed store.
- `trace_addr` out 32, word-aligned byte address of the committed store.
- `trace_data` out 32, full merged word after the committed store.

## Operation
- FSM states: INIT and RUN.
  - Reset forces INIT and sets `init_idx` = 0.
  - INIT: each edge writes 0 to word `init_idx` and increments it. On the edge that clears word DEPTH-1, the FSM moves to RUN.
  - RUN is held until the next reset.
- `ready` = (state == RUN), registered.
- Range check: `oor` = `addr[31:DEPTH_LOG2+2]` != 0.
- Misalignment conditions:
  - sw or lw with `addr[1:0]` != 0;
  - sh or lh/lhu with `addr[0]` != 0;
  - store with `st_c` = 2'b11.
- `err` = `req_valid` & `ready` & (oor | misaligned). It is 0 when `req_valid` = 0 or during INIT.
- `byte_en` is 4'b0000 unless `req_valid` & `we` & `ready` & !`err`. When enabled:
  - sw: 4'b1111;
  - sh: 4'b0011 if `addr[1]` = 0, else 4'b1100;
  - sb: one-hot at bit `addr[1:0]`.
- Store lane data:
  - sw: `wdata`;
  - sh: {`wdata[15:0]`, `wdata[15:0]`};
  - sb: `wdata[7:0]` replicated ×4.
  - Only enabled lanes are written; other bytes of the word keep their value.
- `rdata` rules:
  - array word when `ready` & !oor;
  - 32'h0 during INIT or when out of range;
  - independent of `we` and `err` for in-range addresses.
- Stores that raise `err`, or occur with `ready` low, do not modify the array and produce no trace.
- Committed store: the next edge sets `trace_valid` = 1, `trace_addr` = {`addr[31:2]`, 2'b00}, and `trace_data` = the merged word.
  - `trace_valid` drops after one cycle unless another store commits.
  - `trace_addr` and `trace_data` hold their values between stores.

## Timing
- Reset values: state INIT, `init_idx` 0, `ready` 0, `trace_valid` 0, `trace_addr` 0, `trace_data` 0.
  - `err` and `byte_en` read 0 while `ready` = 0.
  - `rdata` reads 0 during INIT.
- INIT lasts exactly DEPTH rising edges after `reset_n` rises. `ready` is 1 from the DEPTH-th edge onward (1024 edges by default).
- Load latency is 0 cycles: `rdata` is valid in the same cycle `addr` is presented.
- Store latency is 1 edge. A load in the cycle after a store to the same word sees the new data.
- Load and store to the same word in the same cycle: `rdata` shows the old contents.
- Reset asserted mid-INIT or mid-RUN takes effect immediately. The clear restarts at word 0, `ready` drops at once, and any store in flight is discarded.
- Back-to-back stores, one per cycle, are supported with no bubbles. `trace_valid` stays high across consecutive commits.

## Test plan
- Reset release → `ready` = 0 for 1023 edges and 1 after edge 1024 (`DEPTH_LOG2` = 10); lw at 0x0FFC → `rdata` = 0x00000000.
- sw 0x12345678 @0x10, then lb @0x13 → `rdata` = 0x12345678, `byte_en` = 0 on the load, extender lane 3 = 0x12; trace pulse with addr 0x10 and data 0x12345678.
- sb 0xAB @0x11 onto that word → `byte_en` = 4'b0010, next-cycle `rdata` = 0x1234AB78; sh 0xBEEF @0x12 → 4'b1100, `rdata` = 0xBEEFAB78.
- sw @0x22, sh @0x13, lw @0x01, and sw @0x1000 → `err` = 1 each time, word unchanged, no `trace_valid`; `rdata` = 0 for 0x1000.
- Store attempted during INIT at @0x0 with 0xFFFFFFFF → ignored; after `ready`, lw @0x0 → 0x00000000.
- Write 0x55 to word 5, assert `reset_n` low for 1 cycle mid-run → `ready` falls immediately; after re-init, word 5 reads 0.
